// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    OPEN,
    EVENT,
    CLOSE,
    DENY
  } lane_state_t;

  typedef struct packed {
    logic valid;
    logic is_uni;
  } lane_event_t;

  localparam int OPEN_TIMEOUT_DEF = 255;
  localparam int DENY_HOLD_DEF    = 4;

endpackage

// File: rtl/parking_lane_fsm.sv
// One barrier lane: request/vacancy check, open window with pass timeout, event pulse,
// deny hold and a close phase that waits for the car to clear before re-arming.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT  = OPEN_TIMEOUT_DEF,
  parameter int DENY_HOLD     = DENY_HOLD_DEF,
  parameter bit CHECK_VACANCY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_is_uni,
  input  logic        i_passed,
  input  logic        i_vacancy,
  output logic        o_cls,
  output logic        o_gate_open,
  output logic        o_denied,
  output logic        o_timeout,
  output lane_event_t o_event
);

  localparam int TW = $clog2(OPEN_TIMEOUT);
  localparam int DW = $clog2(DENY_HOLD + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [DW-1:0] DENY_LAST  = DW'(DENY_HOLD - 1);

  lane_state_t r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_deny_cnt;
  logic          r_cls;
  logic          r_gate_open;
  logic          r_denied;
  logic          r_timeout;
  lane_event_t   r_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_deny_cnt  <= '0;
      r_cls       <= 1'b0;
      r_gate_open <= 1'b0;
      r_denied    <= 1'b0;
      r_timeout   <= 1'b0;
      r_event     <= '0;
    end else begin
      r_event   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_cls <= i_is_uni;
            if (CHECK_VACANCY) begin
              r_state <= CHECK;
            end else begin
              r_state     <= OPEN;
              r_timer     <= '0;
              r_gate_open <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (i_vacancy) begin
            r_state     <= OPEN;
            r_timer     <= '0;
            r_gate_open <= 1'b1;
          end else begin
            r_state    <= DENY;
            r_deny_cnt <= DENY_LAST;
            r_denied   <= 1'b1;
          end
        end
        OPEN: begin
          // A pass on the timeout edge still counts as a pass.
          if (i_passed) begin
            r_state <= EVENT;
            r_event <= '{valid: 1'b1, is_uni: r_cls};
          end else if (r_timer == TIMER_LAST) begin
            r_state     <= CLOSE;
            r_gate_open <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        EVENT: begin
          r_state     <= CLOSE;
          r_gate_open <= 1'b0;
        end
        CLOSE: begin
          if (!i_passed && !i_req) begin
            r_state <= IDLE;
          end
        end
        DENY: begin
          if (r_deny_cnt == '0) begin
            r_state  <= CLOSE;
            r_denied <= 1'b0;
          end else begin
            r_deny_cnt <= r_deny_cnt - DW'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gate_open <= 1'b0;
          r_denied    <= 1'b0;
        end
      endcase
    end
  end

  assign o_cls       = r_cls;
  assign o_gate_open = r_gate_open;
  assign o_denied    = r_denied;
  assign o_timeout   = r_timeout;
  assign o_event     = r_event;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry and exit barrier controller feeding the occupancy counter with one event per passing car.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int DENY_HOLD    = DENY_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic entry_req,
  input  logic entry_is_uni,
  input  logic entry_passed,
  input  logic exit_req,
  input  logic exit_is_uni,
  input  logic exit_passed,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_timeout,
  output logic exit_timeout
);

  logic        w_entry_cls;
  logic        w_entry_vacancy;
  lane_event_t w_entry_event;
  logic        w_exit_cls;
  logic        w_exit_denied;
  lane_event_t w_exit_event;
  logic        w_unused_exit;

  // Vacancy is judged against the class latched with the request, not the live input.
  assign w_entry_vacancy = w_entry_cls ? uni_is_vacated_space : is_vacated_space;

  parking_lane_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .DENY_HOLD    (DENY_HOLD),
    .CHECK_VACANCY(1'b1)
  ) u_entry_lane (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (entry_req),
    .i_is_uni   (entry_is_uni),
    .i_passed   (entry_passed),
    .i_vacancy  (w_entry_vacancy),
    .o_cls      (w_entry_cls),
    .o_gate_open(entry_gate_open),
    .o_denied   (entry_denied),
    .o_timeout  (entry_timeout),
    .o_event    (w_entry_event)
  );

  parking_lane_fsm #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .DENY_HOLD    (DENY_HOLD),
    .CHECK_VACANCY(1'b0)
  ) u_exit_lane (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (exit_req),
    .i_is_uni   (exit_is_uni),
    .i_passed   (exit_passed),
    .i_vacancy  (1'b0),
    .o_cls      (w_exit_cls),
    .o_gate_open(exit_gate_open),
    .o_denied   (w_exit_denied),
    .o_timeout  (exit_timeout),
    .o_event    (w_exit_event)
  );

  assign w_unused_exit = w_exit_cls ^ w_exit_denied;

  assign car_entered        = w_entry_event.valid;
  assign is_uni_car_entered = w_entry_event.is_uni;
  assign car_exited         = w_exit_event.valid;
  assign is_uni_car_exited  = w_exit_event.is_uni;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scenario bench for parking_gate_ctrl with hand-computed expectations.
module tb_parking_gate_ctrl;

  logic clk;
  logic rst_n;
  logic entry_req, entry_is_uni, entry_passed;
  logic exit_req, exit_is_uni, exit_passed;
  logic uni_is_vacated_space, is_vacated_space;
  logic entry_gate_open, exit_gate_open, entry_denied;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_timeout, exit_timeout;
  logic [8:0] outs;

  int vectors;
  int miscompares;

  parking_gate_ctrl #(
    .OPEN_TIMEOUT(255),
    .DENY_HOLD   (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .entry_req           (entry_req),
    .entry_is_uni        (entry_is_uni),
    .entry_passed        (entry_passed),
    .exit_req            (exit_req),
    .exit_is_uni         (exit_is_uni),
    .exit_passed         (exit_passed),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .entry_gate_open     (entry_gate_open),
    .exit_gate_open      (exit_gate_open),
    .entry_denied        (entry_denied),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .entry_timeout       (entry_timeout),
    .exit_timeout        (exit_timeout)
  );

  assign outs = {entry_gate_open, exit_gate_open, entry_denied, car_entered, is_uni_car_entered,
                 car_exited, is_uni_car_exited, entry_timeout, exit_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    entry_req = 0; entry_is_uni = 0; entry_passed = 0;
    exit_req = 0;  exit_is_uni = 0;  exit_passed = 0;
    uni_is_vacated_space = 1; is_vacated_space = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    entry_req = 1; exit_req = 1;
    rst_n = 1;
    #2 rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (outs !== 9'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc%0d: got %b, expected %b", i, outs, 9'b0);
      end
    end
    rst_n = 1;
    step();
    vectors++;
    if (entry_gate_open !== 1'b0 || exit_gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge: entry_gate=%b exit_gate=%b, expected 0 1",
               entry_gate_open, exit_gate_open);
    end
    step();
    vectors++;
    if (entry_gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_check_to_open: entry_gate=%b, expected 1", entry_gate_open);
    end
    $display("test_reset done");
    do_reset();
  endtask

  task automatic test_entry_uni();
    int pulses;
    pulses = 0;
    entry_is_uni = 1; uni_is_vacated_space = 1; is_vacated_space = 0;
    entry_req = 1;
    step();
    vectors++;
    if (entry_gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_check_gate: got %b, expected 0", entry_gate_open);
    end
    step();
    entry_req = 0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (entry_gate_open !== 1'b1) begin
        miscompares++;
        $display("FAIL entry_open_window cyc%0d: gate=%b, expected 1", i, entry_gate_open);
      end
      if (car_entered) pulses++;
      if (i < 9) step();
    end
    entry_passed = 1;
    step();
    vectors++;
    if (car_entered !== 1'b1 || is_uni_car_entered !== 1'b1 || entry_gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_event: car_entered=%b uni=%b gate=%b, expected 1 1 1",
               car_entered, is_uni_car_entered, entry_gate_open);
    end
    if (car_entered) pulses++;
    step();
    vectors++;
    if (entry_gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_close_after_event: gate=%b, expected 0", entry_gate_open);
    end
    for (int i = 0; i < 4; i++) begin
      if (car_entered) pulses++;
      step();
    end
    entry_passed = 0;
    step(); step();
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL entry_pulse_count: got %0d, expected 1", pulses);
    end
    $display("test_entry_uni done pulses=%0d", pulses);
  endtask

  task automatic test_deny();
    int denied_cycles, opens, pulses;
    denied_cycles = 0; opens = 0; pulses = 0;
    entry_is_uni = 0; is_vacated_space = 0; uni_is_vacated_space = 1;
    entry_req = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (entry_denied === 1'b1) denied_cycles++;
      if (entry_gate_open === 1'b1) opens++;
      if (car_entered === 1'b1) pulses++;
    end
    vectors++;
    if (denied_cycles !== 4) begin
      miscompares++;
      $display("FAIL deny_hold_cycles: got %0d, expected 4", denied_cycles);
    end
    vectors++;
    if (opens !== 0 || pulses !== 0) begin
      miscompares++;
      $display("FAIL deny_no_admit: opens=%0d pulses=%0d, expected 0 0", opens, pulses);
    end
    entry_req = 0;
    is_vacated_space = 1;
    step(); step();
    $display("test_deny done denied_cycles=%0d", denied_cycles);
  endtask

  task automatic test_exit_timeout();
    int open_cycles, pulses, n;
    bit closed;
    open_cycles = 0; pulses = 0; closed = 0; n = 0;
    exit_is_uni = 0; exit_req = 1;
    step();
    while (!closed && n < 400) begin
      if (car_exited === 1'b1) pulses++;
      if (exit_gate_open === 1'b1) begin
        open_cycles++;
        step();
      end else begin
        closed = 1;
      end
      n++;
    end
    vectors++;
    if (!closed || open_cycles !== 255) begin
      miscompares++;
      $display("FAIL exit_timeout_window: open_cycles=%0d closed=%0b, expected 255 1", open_cycles, closed);
    end
    vectors++;
    if (exit_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL exit_timeout_pulse: got %b, expected 1", exit_timeout);
    end
    step();
    vectors++;
    if (exit_timeout !== 1'b0 || pulses !== 0 || car_exited !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_timeout_after: timeout=%b pulses=%0d, expected 0 0", exit_timeout, pulses);
    end
    exit_req = 0;
    step(); step();
    $display("test_exit_timeout done open_cycles=%0d", open_cycles);
  endtask

  task automatic test_same_cycle();
    entry_is_uni = 0; is_vacated_space = 1; uni_is_vacated_space = 0;
    exit_is_uni = 1;
    entry_req = 1; exit_req = 1;
    step(); step();
    entry_req = 0; exit_req = 0;
    vectors++;
    if (entry_gate_open !== 1'b1 || exit_gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL same_both_open: entry=%b exit=%b, expected 1 1", entry_gate_open, exit_gate_open);
    end
    step(); step();
    entry_passed = 1; exit_passed = 1;
    step();
    vectors++;
    if ({car_entered, is_uni_car_entered, car_exited, is_uni_car_exited} !== 4'b1011) begin
      miscompares++;
      $display("FAIL same_cycle_events: got %b, expected %b",
               {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}, 4'b1011);
    end
    entry_passed = 0; exit_passed = 0;
    step();
    vectors++;
    if ({car_entered, car_exited, entry_gate_open, exit_gate_open} !== 4'b0000) begin
      miscompares++;
      $display("FAIL same_cycle_after: got %b, expected 0000",
               {car_entered, car_exited, entry_gate_open, exit_gate_open});
    end
    step(); step();
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_mid_open();
    int pulses;
    pulses = 0;
    entry_is_uni = 1; uni_is_vacated_space = 1; entry_req = 1;
    step(); step();
    vectors++;
    if (entry_gate_open !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_open: gate=%b, expected 1", entry_gate_open);
    end
    #2 rst_n = 0;
    entry_passed = 1;
    #1;
    vectors++;
    if (entry_gate_open !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async_close: gate=%b, expected 0", entry_gate_open);
    end
    step(); step();
    entry_req = 0;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (car_entered === 1'b1 || entry_gate_open === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midreset_no_event: event/open cycles=%0d, expected 0", pulses);
    end
    entry_passed = 0;
    step();
    $display("test_reset_mid_open done");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_inputs();
    rst_n = 1;
    test_reset();
    test_entry_uni();
    test_deny();
    test_exit_timeout();
    test_same_cycle();
    test_reset_mid_open();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
